// File: rtl/fact_accel_if.sv
// fact_accel_if: CPU-side register bus for the factorial accelerator.
//
// Handshake: there is no valid/ready pair. A write happens on every rising
// clk edge where we=1, at word offset a, with data wd. A read is purely
// combinational: rd reflects the register at offset a in the same cycle.
//
// Signals:
//   we  write enable (the address decoder's we_fact)
//   a   word offset within the block (CPU address bits [3:2])
//   wd  CPU write data
//   rd  read data back to the CPU read mux (select 2'b10)
interface fact_accel_if;
  logic        we;
  logic [1:0]  a;
  logic [31:0] wd;
  logic [31:0] rd;

  modport master (output we, output a, output wd, input rd);
  modport slave  (input we, input a, input wd, output rd);
endinterface

// File: rtl/fact_accel.sv
// fact_accel: memory-mapped factorial accelerator (0x800-0x80C).
// Computes n! with one multiply per clock. Software writes N, writes GO,
// then polls STATUS until done is set and reads RESULT.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   bus        fact_accel_if.slave: we, a[1:0], wd[31:0] in; rd[31:0] out
//   state_dbg  current FSM state (0=IDLE, 1=CALC, 2=FIN)
//
// Register map (offset a):
//   00 N       RW, wd[N_W-1:0], reads zero-extended
//   01 GO      W: wd[0]=1 starts when idle; R: {31'b0, busy}
//   10 STATUS  RO: {16'b0, cyc[7:0], 6'b0, err, done}
//   11 RESULT  RO
//
// Optional build macro FACT_CYCLE_CNT_EN adds an 8-bit saturating cycle
// counter at STATUS[15:8]; without it those bits read zero.
module fact_accel #(
  parameter int N_W   = 4,
  parameter int MAX_N = 12
) (
  input  logic         clk,
  input  logic         rst,
  fact_accel_if.slave  bus,
  output logic [1:0]   state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam logic [1:0]     A_N      = 2'b00;
  localparam logic [1:0]     A_GO     = 2'b01;
  localparam logic [1:0]     A_STATUS = 2'b10;
  localparam logic [N_W-1:0] MAX_N_V  = N_W'(MAX_N);
  localparam logic [N_W-1:0] ONE_V    = N_W'(1);

  state_t          state, state_nxt;
  logic [N_W-1:0]  n_reg;
  logic [N_W-1:0]  cnt;
  logic [31:0]     prod;
  logic [31:0]     result;
  logic            done, err, busy;
  logic            err_pend;   // the accepted start had n > MAX_N
  logic [7:0]      cyc_val;

  logic go_wr;
  logic start_acc;
  logic calc_step;

  assign go_wr     = bus.we && (bus.a == A_GO) && bus.wd[0];
  assign state_dbg = state;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and datapath strobes. GO writes outside IDLE fall through
  // untouched, so a start never restarts or queues while busy.
  always_comb begin
    state_nxt = state;
    start_acc = 1'b0;
    calc_step = 1'b0;
    case (state)
      IDLE: begin
        if (go_wr) begin
          start_acc = 1'b1;
          state_nxt = (n_reg > MAX_N_V) ? FIN : CALC;
        end
      end
      CALC: begin
        if (cnt <= ONE_V) state_nxt = FIN;
        else              calc_step = 1'b1;
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Register file and datapath. cnt is a private copy of N taken at start,
  // so N writes during CALC do not disturb the running computation.
  always_ff @(posedge clk) begin
    if (rst) begin
      n_reg    <= '0;
      cnt      <= '0;
      prod     <= 32'd1;
      result   <= 32'd0;
      done     <= 1'b0;
      err      <= 1'b0;
      busy     <= 1'b0;
      err_pend <= 1'b0;
    end else begin
      if (bus.we && (bus.a == A_N)) n_reg <= bus.wd[N_W-1:0];

      if (start_acc) begin
        cnt      <= n_reg;
        prod     <= 32'd1;
        done     <= 1'b0;
        err      <= 1'b0;
        busy     <= 1'b1;
        err_pend <= (n_reg > MAX_N_V);
      end

      if (calc_step) begin
        prod <= prod * {{(32-N_W){1'b0}}, cnt};
        cnt  <= cnt - ONE_V;
      end

      if (state == FIN) begin
        result <= err_pend ? 32'd0 : prod;
        err    <= err_pend;
        done   <= 1'b1;
        busy   <= 1'b0;
      end
    end
  end

`ifdef FACT_CYCLE_CNT_EN
  // Counts cycles spent in CALC and FIN for the last run; holds afterwards.
  logic [7:0] cyc;
  always_ff @(posedge clk) begin
    if (rst)
      cyc <= 8'd0;
    else if (start_acc)
      cyc <= 8'd0;
    else if (((state == CALC) || (state == FIN)) && (cyc != 8'hFF))
      cyc <= cyc + 8'd1;
  end
  assign cyc_val = cyc;
`else
  assign cyc_val = 8'd0;
`endif

  // Combinational read mux.
  always_comb begin
    case (bus.a)
      A_N:      bus.rd = {{(32-N_W){1'b0}}, n_reg};
      A_GO:     bus.rd = {31'b0, busy};
      A_STATUS: bus.rd = {16'b0, cyc_val, 6'b0, err, done};
      default:  bus.rd = result;
    endcase
  end

endmodule

// File: tb/tb_fact_accel.sv
// tb_fact_accel: directed bench for fact_accel. Every driver task starts and
// ends 1 time unit after a rising edge and consumes exactly one clock, so
// latencies are counted in task calls. Reads push an expected value into
// exp_q; the monitor compares on the falling edge while a read is presented.
module tb_fact_accel;

  logic       clk;
  logic       rst;
  logic [1:0] state_dbg;
  logic       rd_req;

  fact_accel_if bus ();

  fact_accel #(.N_W(4), .MAX_N(12)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  string       name_q[$];
  int          checks = 0;
  int          errors = 0;

  always @(negedge clk) begin
    if (rd_req) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_underflow: read with no expected value, rd=0x%08h", bus.rd);
      end else begin
        logic [31:0] e;
        string       n;
        e = exp_q.pop_front();
        n = name_q.pop_front();
        checks++;
        if (bus.rd !== e) begin
          errors++;
          $display("FAIL %s: got 0x%08h expected 0x%08h", n, bus.rd, e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int k);
    bus.we = 1'b0;
    rd_req = 1'b0;
    for (int i = 0; i < k; i++) tick();
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    rd_req = 1'b0;
    bus.we = 1'b1;
    bus.a  = a;
    bus.wd = d;
    tick();
    bus.we = 1'b0;
  endtask

  task automatic rd_chk(input logic [1:0] a, input logic [31:0] e, input string n);
    bus.we = 1'b0;
    bus.a  = a;
    exp_q.push_back(e);
    name_q.push_back(n);
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
  endtask

  task automatic do_reset();
    rd_req = 1'b0;
    bus.we = 1'b0;
    rst    = 1'b1;
    tick();
    rst    = 1'b0;
  endtask

  function automatic logic [31:0] status_exp(input int cyc, input logic e, input logic d);
    logic [7:0] c;
`ifdef FACT_CYCLE_CNT_EN
    c = (cyc > 255) ? 8'hFF : 8'(cyc);
`else
    c = 8'd0;
`endif
    return {16'b0, c, 6'b0, e, d};
  endfunction

  // Start a run and check status just before and just after done,
  // then RESULT, busy and N. lat = edges after the accept edge to done.
  task automatic run_fact(input int n, input logic [31:0] res, input logic e);
    int lat;
    lat = e ? 1 : ((n > 1 ? n : 1) + 1);
    wr(2'b00, 32'(n));
    wr(2'b01, 32'h1);
    idle(lat - 1);
    rd_chk(2'b10, status_exp(lat - 1, 1'b0, 1'b0), $sformatf("status_pre_n%0d", n));
    rd_chk(2'b10, status_exp(lat, e, 1'b1), $sformatf("status_done_n%0d", n));
    rd_chk(2'b11, res, $sformatf("result_n%0d", n));
    rd_chk(2'b01, 32'h0, $sformatf("busy_clear_n%0d", n));
    rd_chk(2'b00, 32'(n), $sformatf("n_readback_n%0d", n));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst    = 1'b1;
    rd_req = 1'b0;
    bus.we = 1'b0;
    bus.a  = 2'b00;
    bus.wd = 32'h0;
    tick();
    tick();
    rst = 1'b0;

    // Reset values.
    rd_chk(2'b00, 32'h0, "reset_n");
    rd_chk(2'b01, 32'h0, "reset_go");
    rd_chk(2'b10, 32'h0, "reset_status");
    rd_chk(2'b11, 32'h0, "reset_result");

    // Normal runs, including both n=0/1 edge cases and the largest legal n.
    run_fact(5,  32'h0000_0078, 1'b0);
    run_fact(12, 32'h1C8C_FC00, 1'b0);
    run_fact(0,  32'h0000_0001, 1'b0);
    run_fact(1,  32'h0000_0001, 1'b0);

    // Writes to STATUS/RESULT ignored; GO with wd[0]=0 does nothing.
    wr(2'b11, 32'hDEAD_BEEF);
    wr(2'b10, 32'hFFFF_FFFF);
    wr(2'b01, 32'hFFFF_FFFE);
    rd_chk(2'b01, 32'h0, "go_bit0_zero_no_start");
    rd_chk(2'b11, 32'h0000_0001, "result_write_ignored");
    rd_chk(2'b10, status_exp(2, 1'b0, 1'b1), "status_write_ignored");

    // Overflow error, then a good run clears err.
    run_fact(13, 32'h0, 1'b1);
    run_fact(3,  32'h0000_0006, 1'b0);

    // GO while busy is ignored; N write mid-run does not affect result.
    wr(2'b00, 32'd10);
    wr(2'b01, 32'h1);          // accept edge E0
    wr(2'b01, 32'h1);          // E1, ignored
    wr(2'b00, 32'd2);          // E2
    rd_chk(2'b01, 32'h1, "busy_during_calc");          // sampled E2..E3
    rd_chk(2'b11, 32'h0000_0006, "result_holds_mid_run"); // E3..E4
    idle(6);                                            // through E10
    rd_chk(2'b10, status_exp(10, 1'b0, 1'b0), "status_pre_busytest");
    rd_chk(2'b10, status_exp(11, 1'b0, 1'b1), "status_done_busytest");
    rd_chk(2'b11, 32'h0037_5F00, "result_busytest");
    rd_chk(2'b00, 32'd2, "n_updated_mid_run");

    // Reset mid-CALC aborts the run.
    wr(2'b00, 32'd8);
    wr(2'b01, 32'h1);
    idle(3);
    do_reset();
    rd_chk(2'b01, 32'h0, "abort_busy");
    rd_chk(2'b00, 32'h0, "abort_n");
    rd_chk(2'b11, 32'h0, "abort_result");
    idle(10);
    rd_chk(2'b10, 32'h0, "abort_no_spurious_done");

    // Reset and GO write in the same cycle: reset wins.
    wr(2'b00, 32'd4);
    rst    = 1'b1;
    wr(2'b01, 32'h1);
    rst    = 1'b0;
    rd_chk(2'b01, 32'h0, "rst_wins_over_go");
    idle(8);
    rd_chk(2'b10, 32'h0, "rst_wins_no_done");

    idle(2);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_leftover: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
